// File: rtl/buzzer_melody_gen.sv
// Melody player for the piezo buzzer: steps through a small note ROM and drives
// a 50%-duty square wave per note, with rests, inter-note gaps, mute and retrigger.
module buzzer_melody_gen #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned UNIT_CYCLES = 5_000_000,
    parameter int unsigned GAP_CYCLES  = 250_000,
    parameter int unsigned DIV_W       = 17,
    parameter int unsigned DUR_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] melody_sel,
    input  logic       mute,
    output logic       busy,
    output logic       done,
    output logic       buzzer
);

    // Terminal counts; counters run 0..N-1.
    localparam logic [DIV_W-1:0] HP_DO_LAST  = DIV_W'(CLK_HZ / (2 * 262) - 1);
    localparam logic [DIV_W-1:0] HP_MI_LAST  = DIV_W'(CLK_HZ / (2 * 330) - 1);
    localparam logic [DIV_W-1:0] HP_SOL_LAST = DIV_W'(CLK_HZ / (2 * 392) - 1);
    localparam logic [DIV_W-1:0] HP_LA_LAST  = DIV_W'(CLK_HZ / (2 * 440) - 1);
    localparam logic [DUR_W-1:0] DUR1_LAST   = DUR_W'(UNIT_CYCLES - 1);
    localparam logic [DUR_W-1:0] DUR2_LAST   = DUR_W'(2 * UNIT_CYCLES - 1);
    localparam logic [DUR_W-1:0] GAP_LAST    = DUR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               HAS_GAP     = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;
    typedef enum logic [2:0] {NOTE_DO, NOTE_MI, NOTE_SOL, NOTE_LA, NOTE_REST} note_e;

    typedef struct packed {
        note_e note;
        logic  two_units;
        logic  last;
    } rom_entry_t;

    // Melody ROM indexed by {melody, note index}.
    function automatic rom_entry_t rom_lookup(input logic [1:0] sel, input logic [1:0] idx);
        rom_entry_t e;
        case ({sel, idx})
            4'b00_00: e = '{NOTE_DO,   1'b1, 1'b1};
            4'b01_00: e = '{NOTE_DO,   1'b0, 1'b0};
            4'b01_01: e = '{NOTE_MI,   1'b0, 1'b0};
            4'b01_10: e = '{NOTE_SOL,  1'b0, 1'b1};
            4'b10_00: e = '{NOTE_SOL,  1'b0, 1'b0};
            4'b10_01: e = '{NOTE_MI,   1'b0, 1'b0};
            4'b10_10: e = '{NOTE_DO,   1'b0, 1'b1};
            4'b11_00: e = '{NOTE_LA,   1'b0, 1'b0};
            4'b11_01: e = '{NOTE_REST, 1'b0, 1'b0};
            4'b11_10: e = '{NOTE_LA,   1'b0, 1'b0};
            4'b11_11: e = '{NOTE_REST, 1'b0, 1'b1};
            default:  e = '{NOTE_REST, 1'b0, 1'b1};
        endcase
        return e;
    endfunction

    state_e            state_q;
    logic [1:0]        sel_q;
    logic [1:0]        idx_q;
    logic [DIV_W-1:0]  phase_q;
    logic [DUR_W-1:0]  dur_q;
    logic              tone_q;
    logic              tone_d;
    rom_entry_t        cur_c;
    logic [DIV_W-1:0]  hp_last_c;
    logic [DUR_W-1:0]  dur_last_c;
    logic              note_end_c;

    assign cur_c      = rom_lookup(sel_q, idx_q);
    assign dur_last_c = cur_c.two_units ? DUR2_LAST : DUR1_LAST;
    assign note_end_c = (dur_q == dur_last_c);

    always_comb begin
        hp_last_c = HP_DO_LAST;
        case (cur_c.note)
            NOTE_MI:  hp_last_c = HP_MI_LAST;
            NOTE_SOL: hp_last_c = HP_SOL_LAST;
            NOTE_LA:  hp_last_c = HP_LA_LAST;
            default:  hp_last_c = HP_DO_LAST;
        endcase
    end

    // Next tone bit; buzzer registers it directly so the first rise lands HP cycles into PLAY.
    always_comb begin
        tone_d = 1'b0;
        if (!start && state_q == S_PLAY && !note_end_c) begin
            tone_d = tone_q;
            if (phase_q == hp_last_c && cur_c.note != NOTE_REST) begin
                tone_d = ~tone_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            idx_q   <= 2'd0;
            phase_q <= '0;
            dur_q   <= '0;
            tone_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            buzzer  <= 1'b0;
        end else begin
            done   <= 1'b0;
            tone_q <= tone_d;
            buzzer <= tone_d & ~mute;
            if (start) begin
                // Start and retrigger are identical: restart at note 0 of the new melody.
                state_q <= S_PLAY;
                sel_q   <= melody_sel;
                idx_q   <= 2'd0;
                phase_q <= '0;
                dur_q   <= '0;
                busy    <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        busy <= 1'b0;
                    end
                    S_PLAY: begin
                        if (note_end_c) begin
                            phase_q <= '0;
                            dur_q   <= '0;
                            if (HAS_GAP) begin
                                state_q <= S_GAP;
                            end else if (cur_c.last) begin
                                state_q <= S_IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 2'd1;
                            end
                        end else begin
                            dur_q <= dur_q + DUR_W'(1);
                            if (phase_q == hp_last_c) begin
                                phase_q <= '0;
                            end else begin
                                phase_q <= phase_q + DIV_W'(1);
                            end
                        end
                    end
                    S_GAP: begin
                        if (dur_q == GAP_LAST) begin
                            dur_q <= '0;
                            if (cur_c.last) begin
                                state_q <= S_IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                state_q <= S_PLAY;
                                idx_q   <= idx_q + 2'd1;
                            end
                        end else begin
                            dur_q <= dur_q + DUR_W'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buzzer_melody_gen.sv
// Randomised bench for buzzer_melody_gen against a time-offset melody model.
module tb_buzzer_melody_gen;

    localparam int CLK_HZ = 100_000;
    localparam int UNIT   = 1000;
    localparam int GAP    = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] melody_sel = 2'd0;
    logic       mute = 1'b0;
    logic       busy;
    logic       done;
    logic       buzzer;

    int n_vec = 0;
    int n_err = 0;

    // Model: melody currently expected and how many cycles it has been busy.
    bit m_active = 1'b0;
    int m_sel = 0;
    int m_c = 0;

    always #5 clk = ~clk;

    buzzer_melody_gen #(
        .CLK_HZ     (CLK_HZ),
        .UNIT_CYCLES(UNIT),
        .GAP_CYCLES (GAP),
        .DIV_W      (17),
        .DUR_W      (26)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .melody_sel(melody_sel),
        .mute      (mute),
        .busy      (busy),
        .done      (done),
        .buzzer    (buzzer)
    );

    function automatic int mel_len(input int sel);
        return (sel == 0) ? 1 : ((sel == 3) ? 4 : 3);
    endfunction

    function automatic int mel_units(input int sel);
        return (sel == 0) ? 2 : 1;
    endfunction

    // Note frequency in Hz, 0 for a rest.
    function automatic int mel_freq(input int sel, input int i);
        case (sel)
            0:       return 262;
            1:       return (i == 0) ? 262 : ((i == 1) ? 330 : 392);
            2:       return (i == 0) ? 392 : ((i == 1) ? 330 : 262);
            default: return (i % 2 == 0) ? 440 : 0;
        endcase
    endfunction

    function automatic int mel_total(input int sel);
        return mel_len(sel) * (mel_units(sel) * UNIT + GAP);
    endfunction

    // Expected tone level c cycles after busy rose.
    function automatic bit ref_tone(input int sel, input int c);
        int off;
        int d;
        int f;
        off = c;
        d   = mel_units(sel) * UNIT;
        for (int i = 0; i < mel_len(sel); i++) begin
            if (off < d + GAP) begin
                f = mel_freq(sel, i);
                if (off >= d || f == 0) return 1'b0;
                return ((off / (CLK_HZ / (2 * f))) % 2) == 1;
            end
            off -= d + GAP;
        end
        return 1'b0;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t sel=%0d c=%0d got=%b exp=%b", tag, $time, m_sel, m_c, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check at the falling edge.
    task automatic step(input bit st, input int sel, input bit mu, input bit rs);
        bit e_busy;
        bit e_done;
        bit e_buz;
        start      = st;
        melody_sel = 2'(sel);
        mute       = mu;
        rst        = rs;
        @(posedge clk);
        if (rs) begin
            m_active = 1'b0;
            m_c      = 0;
        end else if (st) begin
            m_active = 1'b1;
            m_sel    = sel;
            m_c      = 0;
        end else if (m_active) begin
            m_c++;
        end
        e_busy = 1'b0;
        e_done = 1'b0;
        e_buz  = 1'b0;
        if (m_active) begin
            if (m_c < mel_total(m_sel)) begin
                e_busy = 1'b1;
                e_buz  = ref_tone(m_sel, m_c) && !mu;
            end else begin
                e_done   = 1'b1;
                m_active = 1'b0;
            end
        end
        @(negedge clk);
        check_bit("busy", busy, e_busy);
        check_bit("done", done, e_done);
        check_bit("buzzer", buzzer, e_buz);
    endtask

    // Start a melody, optionally retrigger / mute / reset at given busy cycles (-1 = never).
    task automatic run_scn(input int sel, input int rt_at, input int rt_sel,
                           input int mu_from, input int mu_to, input int rs_at);
        int lim;
        bit st;
        lim = mel_total(sel) + 20;
        if (rt_at >= 0) lim = rt_at + mel_total(rt_sel) + 20;
        step(1'b1, sel, 1'b0, 1'b0);
        for (int c = 0; c < lim; c++) begin
            st = (c == rt_at);
            step(st, st ? rt_sel : int'($urandom_range(0, 3)),
                 (c >= mu_from && c < mu_to), (c == rs_at));
        end
    endtask

    initial begin
        int sel;
        int tot;
        int rt;
        int rts;
        int mf;
        int rs;
        for (int i = 0; i < 3; i++) step(1'b1, i, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0, 1'b0);

        run_scn(0, -1, 0, -1, -1, -1);
        run_scn(1, -1, 0, -1, -1, -1);
        run_scn(3, -1, 0, -1, -1, -1);
        run_scn(1, 1500, 0, -1, -1, -1);
        run_scn(0, -1, 0, 300, 800, -1);
        run_scn(2, -1, 0, -1, -1, 1234);
        run_scn(0, 2099, 2, -1, -1, -1);

        for (int k = 0; k < 6; k++) begin
            sel = int'($urandom_range(0, 3));
            tot = mel_total(sel);
            rt  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, tot - 1)) : -1;
            rts = int'($urandom_range(0, 3));
            mf  = int'($urandom_range(0, tot - 1));
            rs  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
            run_scn(sel, rt, rts, mf, mf + int'($urandom_range(0, 600)), rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
